if_fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the 5-stage MIPS core. It replaces the single-register IF stage.
- Drives the inst_sram port, tracks the one-cycle SRAM read latency, and buffers up to DEPTH fetched {pc, inst} entries.
- Presents entries to ID over a valid/ready handshake.
- Supports same-cycle redirect (branch, jump, exception, eret) with kill of in-flight reads, and flags misaligned fetch addresses as AdEL.

---
 rtl/core_pkg.sv | 22 ++
 rtl/fetch_fifo_mem.sv | 25 ++
 rtl/if_fetch_queue.sv | 159 +++++++++++++++
 tb/tb_if_fetch_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: fetch queue entry layout, reset vector and exception codes.
package core_pkg;

  localparam int unsigned CORE_ADDR_W = 32;
  localparam int unsigned CORE_DATA_W = 32;

  localparam logic [CORE_ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // ExcCode for address error on load/fetch; the exception handler decodes the same value.
  localparam logic [4:0] EXC_ADEL = 5'h04;

  typedef struct packed {
    logic [CORE_ADDR_W-1:0] pc;
    logic [CORE_DATA_W-1:0] inst;
    logic                   adel;
  } fetch_entry_t;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo_mem.sv
// Register array backing the fetch queue: one synchronous write port, combinational head read.
module fetch_fifo_mem #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = core_pkg::fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  entry_t                   wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output entry_t                   rd_data
);

  entry_t mem [DEPTH];

  // Contents need no reset: the top only trusts slots between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues SRAM reads, tracks the one-cycle read latency and
// buffers fetched {pc, inst, adel} entries for ID behind a valid/ready handshake.
module if_fetch_queue
  import core_pkg::*;
#(
  parameter int unsigned         DEPTH    = 4,
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_wen,
  output logic [ADDR_W-1:0]          inst_sram_addr,
  output logic [DATA_W-1:0]          inst_sram_wdata,
  input  logic [DATA_W-1:0]          inst_sram_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_inst,
  output logic                       out_adel,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              adel;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              halted_q, halted_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;

  logic [PTR_W:0]    occ;
  logic [PTR_W+1:0]  credit;
  logic              empty;
  logic              credit_ok;
  logic              issue;
  logic              fetch_aligned;
  logic              redirect_aligned;
  logic              sram_req;
  logic              push;
  logic              pop;
  entry_t            push_entry;
  entry_t            head;

  assign occ              = wr_ptr_q - rd_ptr_q;
  assign empty            = (occ == '0);
  // Credits count the in-flight read so its response always finds a free slot.
  assign credit           = {1'b0, occ} + (PTR_W+2)'(inflight_q);
  assign credit_ok        = credit < (PTR_W+2)'(DEPTH);
  assign issue            = !halted_q && credit_ok;
  assign fetch_aligned    = is_word_aligned(fetch_pc_q[1:0]);
  assign redirect_aligned = is_word_aligned(redirect_pc[1:0]);

  always_comb begin
    sram_req       = 1'b0;
    inst_sram_addr = fetch_pc_q;
    push           = 1'b0;
    pop            = 1'b0;
    push_entry     = '0;
    fetch_pc_d     = fetch_pc_q;
    inflight_d     = inflight_q;
    inflight_pc_d  = inflight_pc_q;
    halted_d       = halted_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;

    if (redirect_valid) begin
      // Flush: drop queue contents, the pending response and any same-cycle pop.
      inst_sram_addr = redirect_pc;
      sram_req       = redirect_aligned;
      fetch_pc_d     = redirect_aligned ? redirect_pc + ADDR_W'(4) : redirect_pc;
      inflight_d     = redirect_aligned;
      inflight_pc_d  = redirect_pc;
      halted_d       = 1'b0;
      rd_ptr_d       = wr_ptr_q;
    end else begin
      pop = !empty && out_ready;

      if (inflight_q) begin
        push            = 1'b1;
        push_entry.pc   = inflight_pc_q;
        push_entry.inst = inst_sram_rdata;
        push_entry.adel = 1'b0;
        inflight_d      = 1'b0;
      end

      if (issue && fetch_aligned) begin
        sram_req      = 1'b1;
        fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end else if (issue && !inflight_q) begin
        // Misaligned fetch: queue the AdEL marker once older responses have drained.
        push            = 1'b1;
        push_entry.pc   = fetch_pc_q;
        push_entry.inst = '0;
        push_entry.adel = 1'b1;
        halted_d        = 1'b1;
      end

      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      halted_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      halted_q      <= halted_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  fetch_fifo_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q[PTR_W-1:0]),
    .wr_data (push_entry),
    .rd_addr (rd_ptr_q[PTR_W-1:0]),
    .rd_data (head)
  );

  // Gated by resetn so the enable drops the moment reset asserts.
  assign inst_sram_en    = sram_req && resetn;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = '0;

  assign out_valid = !empty;
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_inst  = (out_valid && !head.adel) ? head.inst : '0;
  assign out_adel  = out_valid && head.adel;
  assign count     = CNT_W'(occ);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a one-cycle-latency instruction SRAM model.
module tb_if_fetch_queue;

  logic        clk;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;
  logic [2:0]  count;

  int passed;
  int total;

  if_fetch_queue #(
    .DEPTH    (4),
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'hBFC0_0000)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_adel        (out_adel),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  initial inst_sram_rdata = 32'h0;
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= sram_word(inst_sram_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("count_le_depth", 64'(count <= 3'd4), 64'd1);
    chk("valid_matches_count", 64'(out_valid), 64'(count != 3'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    bit          hit;
    passed = 0;
    total  = 0;
    resetn = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 64'(inst_sram_en), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_inst", 64'(out_inst), 64'd0);
    chk("rst_adel", 64'(out_adel), 64'd0);
    chk("wen_zero", 64'(inst_sram_wen), 64'd0);
    chk("wdata_zero", 64'(inst_sram_wdata), 64'd0);

    // Reset release: streaming fetch with ID always ready.
    resetn = 1'b1;
    #1;
    chk("c0_en", 64'(inst_sram_en), 64'd1);
    chk("c0_addr", 64'(inst_sram_addr), 64'hBFC0_0000);
    tick();
    chk("c1_addr", 64'(inst_sram_addr), 64'hBFC0_0004);
    chk("c1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("c2_valid", 64'(out_valid), 64'd1);
    chk("c2_pc", 64'(out_pc), 64'hBFC0_0000);
    chk("c2_inst", 64'(out_inst), 64'(sram_word(32'hBFC0_0000)));
    chk("c2_count", 64'(count), 64'd1);
    tick();
    chk("c3_pc", 64'(out_pc), 64'hBFC0_0004);
    tick();
    chk("c4_pc", 64'(out_pc), 64'hBFC0_0008);

    // Backpressure: queue fills to DEPTH, fetch stops, head holds.
    out_ready = 1'b0;
    repeat (9) tick();
    chk("stall_count", 64'(count), 64'd4);
    chk("stall_en", 64'(inst_sram_en), 64'd0);
    chk("stall_head", 64'(out_pc), 64'hBFC0_0008);
    out_ready = 1'b1;
    base = 32'hBFC0_0008;
    for (int i = 0; i < 6; i++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_pc", 64'(out_pc), 64'(base + 32'(4 * i)));
      chk("drain_inst", 64'(out_inst), 64'(sram_word(base + 32'(4 * i))));
      tick();
    end

    // Redirect with three entries queued and one read in flight.
    out_ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (count == 3'd3) hit = 1'b1;
      else tick();
    end
    chk("wait_count3", 64'(hit), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1000;
    #1;
    chk("redir_en", 64'(inst_sram_en), 64'd1);
    chk("redir_addr", 64'(inst_sram_addr), 64'h8000_1000);
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush_count", 64'(count), 64'd0);
    tick();
    chk("redir_valid", 64'(out_valid), 64'd1);
    chk("redir_pc", 64'(out_pc), 64'h8000_1000);
    chk("redir_inst", 64'(out_inst), 64'(sram_word(32'h8000_1000)));
    out_ready = 1'b1;
    tick();
    chk("redir_next_pc", 64'(out_pc), 64'h8000_1004);

    // Misaligned redirect: single AdEL entry, then halted until the next redirect.
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1002;
    #1;
    chk("mis_en_r", 64'(inst_sram_en), 64'd0);
    tick();
    redirect_valid = 1'b0;
    chk("mis_valid_r1", 64'(out_valid), 64'd0);
    chk("mis_en_r1", 64'(inst_sram_en), 64'd0);
    tick();
    chk("mis_valid", 64'(out_valid), 64'd1);
    chk("mis_pc", 64'(out_pc), 64'h8000_1002);
    chk("mis_adel", 64'(out_adel), 64'd1);
    chk("mis_inst", 64'(out_inst), 64'd0);
    chk("mis_en", 64'(inst_sram_en), 64'd0);
    tick();
    chk("mis_single", 64'(out_valid), 64'd0);
    repeat (3) tick();
    chk("halt_en", 64'(inst_sram_en), 64'd0);
    chk("halt_count", 64'(count), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_2000;
    #1;
    chk("resume_en", 64'(inst_sram_en), 64'd1);
    chk("resume_addr", 64'(inst_sram_addr), 64'h8000_2000);
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("resume_pc", 64'(out_pc), 64'h8000_2000);
    chk("resume_adel", 64'(out_adel), 64'd0);
    chk("resume_inst", 64'(out_inst), 64'(sram_word(32'h8000_2000)));

    // Redirect coinciding with a pop while full: pop is void, stream restarts.
    out_ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      if (count == 3'd4) hit = 1'b1;
      else tick();
    end
    chk("wait_full", 64'(hit), 64'd1);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_3000;
    tick();
    redirect_valid = 1'b0;
    chk("fullredir_count", 64'(count), 64'd0);
    chk("fullredir_valid", 64'(out_valid), 64'd0);
    tick();
    chk("fullredir_pc0", 64'(out_pc), 64'h8000_3000);
    tick();
    chk("fullredir_pc1", 64'(out_pc), 64'h8000_3004);

    // Reset pulse mid-stream with a read in flight.
    resetn = 1'b0;
    #1;
    chk("arst_en", 64'(inst_sram_en), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_pc", 64'(out_pc), 64'd0);
    tick();
    resetn = 1'b1;
    #1;
    chk("rerst_en", 64'(inst_sram_en), 64'd1);
    chk("rerst_addr", 64'(inst_sram_addr), 64'hBFC0_0000);
    chk("rerst_count", 64'(count), 64'd0);
    tick();
    chk("rerst_stale", 64'(out_valid), 64'd0);
    tick();
    chk("rerst_pc", 64'(out_pc), 64'hBFC0_0000);
    chk("rerst_inst", 64'(out_inst), 64'(sram_word(32'hBFC0_0000)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
